branch_predictor_dual: RTL and testbench
========================================

# branch_predictor_dual

Dynamic branch direction predictor for the dual-issue pipeline. It looks up a table of 2-bit saturating counters in F using the PC of the first branch in the fetched pair. The result is registered into the F/D latch and drives `branchPredictedTaken` for the D/X decoder. Resolved outcomes from X train the table, raise the mispredict flag and update performance counters.

## Interface
- `INDEX_BITS`, default 6: table index width; the table holds 2^INDEX_BITS entries.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `fd_enable` in 1: F/D latch enable; low means stall and hold.
- `fd_flush` in 1: clears the registered prediction; takes priority over `fd_enable`.
- `f_pc_top`, `f_pc_bot` in 32: F-stage PCs of the two lanes.
- `f_insn_top`, `f_insn_bot` in 32: F-stage instructions of the two lanes.
- `branchPredictedTaken` out 1: registered D-stage prediction.
- `d_pred_lane` out 1: lane the prediction belongs to; 0 = top, 1 = bot.
- `x_valid` in 1: a branch resolves in X this cycle.
- `x_pc` in 32: PC of the resolving branch.
- `x_taken` in 1: actual outcome of the resolving branch.
- `x_predicted` in 1: prediction carried down the pipe with that branch.
- `mispredict` out 1: combinational, `x_valid & (x_taken ^ x_predicted)`.
- `stat_branches`, `stat_mispredicts` out 32: saturating event counters.

## Operation
- **Branch detect.** The opcode is `insn[31:27]`.
  - bne = 00010, blt = 00110, bex = 10110.
  - Other opcodes are not branches.
- **Lane select.**
  - If the top instruction is a branch, use the top lane.
  - Otherwise, if the bottom instruction is a branch, use the bottom lane.
  - Otherwise there is no branch.
  - When both lanes hold branches, only top is predicted; the bottom branch gets no prediction from this block.
- **Lookup.**
  - Index = selected PC `[INDEX_BITS-1:0]`; PCs are word-addressed, so there is no offset drop.
  - Prediction = counter bit 1. With no branch, prediction = 0.
- **Counter encoding.** 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Update.**
  - Occurs when `x_valid`, at index `x_pc[INDEX_BITS-1:0]`.
  - Taken: increment, saturating at 11. Not taken: decrement, saturating at 00.
- **Read bypass.** If the update index equals the lookup index in the same cycle, the lookup uses the post-update counter value.
- **Aliasing.** PCs that differ only above `INDEX_BITS` share an entry. This is intended; there are no tags.
- **Statistics.**
  - `stat_branches` increments on each `x_valid`.
  - `stat_mispredicts` increments on each `mispredict`.
  - Both hold at 0xFFFFFFFF.

## Timing
- **Reset values.** Reset asserted immediately forces:
  - every table entry to 01;
  - `branchPredictedTaken`, `d_pred_lane` to 0;
  - both stat counters to 0.
- **Latency.**
  - An F lookup in cycle N appears on `branchPredictedTaken` in cycle N+1.
  - A table update issued in cycle N is visible to lookups in cycle N via the bypass, and is stored at the edge ending cycle N.
- **F/D register priority.**
  - `fd_flush` = 1: output registers load 0.
  - Else `fd_enable` = 0: output registers hold.
  - Else: output registers load the new prediction and lane.
- **Updates are independent of stall and flush.** A training update is still applied when `fd_enable` = 0 or `fd_flush` = 1.
- **Reset mid-operation.** Deasserting reset mid-stream loses all training. The first post-reset lookup predicts not-taken.
- **`mispredict`** is purely combinational, with no state. The flush consumer registers it.

## Structure
- **Shared package `bp_pkg`:**
  - opcode constants `OP_BNE`, `OP_BLT`, `OP_BEX`;
  - counter constants `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`;
  - `CTR_RESET` = `CTR_WNT`;
  - a saturating increment/decrement function.
- **Sub-module `bp_pattern_table`.** Holds the counter array and implements:
  - the asynchronous reset;
  - one combinational read port with the write-to-read bypass;
  - one write port.

  The top level holds the branch detect, lane select, F/D register, mispredict logic and stat counters.

## Test plan
- **Reset.** Drive top = bne at PC 5 with `fd_enable` = 1 → `branchPredictedTaken` = 0 and `d_pred_lane` = 0 next cycle; stats = 0.
- **Training and saturation.**
  - Send two `x_valid` taken updates at `x_pc` = 5, then fetch bne at PC 5 → prediction 1.
  - Send three more taken updates, then one not-taken → prediction still 1 (11→10).
- **Bypass and aliasing.**
  - With entry 5 at 01, apply a taken update at `x_pc` = 5 in the same cycle as fetching PC 5 → prediction 1 next cycle.
  - Fetch PC 69 with `INDEX_BITS` = 6 → prediction 1 (shared entry).
- **Lane select.**
  - Top = add, bot = blt at PC 12 with entry 12 = 11 → pred 1, lane 1.
  - Top = bex at PC 20 (entry 01), bot = bne at PC 21 (entry 11) → pred 0, lane 0.
- **Stall, flush and statistics.**
  - Hold `fd_enable` = 0 for 3 cycles while the F instruction changes → output holds.
  - Assert `fd_flush` with `fd_enable` = 0 → output goes to 0.
  - Four resolutions with `x_taken` ^ `x_predicted` = 1,0,1,1 → `mispredict` pulses three times; `stat_branches` = 4, `stat_mispredicts` = 3.
- **Reset mid-operation.** Train entry 7 to 11, pulse `reset_n` low for half a cycle → asynchronous clear of outputs. Then fetch PC 7 → prediction 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the dual-issue branch direction predictor.
// Opcode and counter encodings plus the saturating counter step.
package bp_pkg;

    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_BEX = 5'b10110;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

    function automatic logic [1:0] ctrNext(
        input logic [1:0] ctr,
        input logic       taken
    );
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

    function automatic logic isBranch(input logic [31:0] insn);
        return (insn[31:27] == OP_BNE) ||
               (insn[31:27] == OP_BLT) ||
               (insn[31:27] == OP_BEX);
    endfunction

endpackage

// File: rtl/bp_pattern_table.sv
// Untagged table of 2-bit saturating counters with one read
// port (write bypass) and one training write port.
module bp_pattern_table
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [INDEX_BITS-1:0] rdIdx,
    output logic [1:0]            rdCtr,
    input  logic                  wrEn,
    input  logic [INDEX_BITS-1:0] wrIdx,
    input  logic                  wrTaken
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [1:0] ctrs [DEPTH];
    logic [1:0] wrCtr;

    assign wrCtr = ctrNext(ctrs[wrIdx], wrTaken);

    // Same-cycle training is visible to the lookup.
    assign rdCtr = (wrEn && (wrIdx == rdIdx)) ? wrCtr : ctrs[rdIdx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctrs[i] <= CTR_RESET;
            end
        end else if (wrEn) begin
            ctrs[wrIdx] <= wrCtr;
        end
    end

endmodule

// File: rtl/branch_predictor_dual.sv
// Dual-lane branch direction predictor: F lookup, F/D register,
// X-stage training, mispredict flag and event counters.
module branch_predictor_dual
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fd_enable,
    input  logic        fd_flush,
    input  logic [31:0] f_pc_top,
    input  logic [31:0] f_pc_bot,
    input  logic [31:0] f_insn_top,
    input  logic [31:0] f_insn_bot,
    output logic        branchPredictedTaken,
    output logic        d_pred_lane,
    input  logic        x_valid,
    input  logic [31:0] x_pc,
    input  logic        x_taken,
    input  logic        x_predicted,
    output logic        mispredict,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    logic                  topBr;
    logic                  botBr;
    logic                  hasBr;
    logic                  selLane;
    logic [INDEX_BITS-1:0] lkIdx;
    logic [1:0]            lkCtr;
    logic                  nextPred;

    assign topBr = isBranch(f_insn_top);
    assign botBr = isBranch(f_insn_bot);

    // Top lane wins when both lanes hold branches.
    always_comb begin
        hasBr   = 1'b0;
        selLane = 1'b0;
        lkIdx   = f_pc_top[INDEX_BITS-1:0];
        unique case (1'b1)
            topBr: begin
                hasBr = 1'b1;
            end
            (!topBr && botBr): begin
                hasBr   = 1'b1;
                selLane = 1'b1;
                lkIdx   = f_pc_bot[INDEX_BITS-1:0];
            end
            default: ;
        endcase
    end

    bp_pattern_table #(
        .INDEX_BITS(INDEX_BITS)
    ) u_table (
        .clock  (clock),
        .reset_n(reset_n),
        .rdIdx  (lkIdx),
        .rdCtr  (lkCtr),
        .wrEn   (x_valid),
        .wrIdx  (x_pc[INDEX_BITS-1:0]),
        .wrTaken(x_taken)
    );

    assign nextPred   = hasBr & lkCtr[1];
    assign mispredict = x_valid & (x_taken ^ x_predicted);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            branchPredictedTaken <= 1'b0;
            d_pred_lane          <= 1'b0;
        end else if (fd_flush) begin
            branchPredictedTaken <= 1'b0;
            d_pred_lane          <= 1'b0;
        end else if (fd_enable) begin
            branchPredictedTaken <= nextPred;
            d_pred_lane          <= selLane;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (x_valid && (stat_branches != '1)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_dual.sv
// Directed vector bench for branch_predictor_dual.
// Table-driven vectors plus stall, flush, reset and stats sequences.
module tb_branch_predictor_dual;

    localparam logic [31:0] BNE  = 32'h1000_0000;
    localparam logic [31:0] BLT  = 32'h3000_0000;
    localparam logic [31:0] BEX  = 32'hB000_0000;
    localparam logic [31:0] ADD  = 32'h0000_0000;
    localparam logic [31:0] NEAR = 32'h1800_0000;

    typedef struct {
        logic        en;
        logic        fl;
        logic [31:0] pcT;
        logic [31:0] inT;
        logic [31:0] pcB;
        logic [31:0] inB;
        logic        xv;
        logic [31:0] xpc;
        logic        xt;
        logic        xp;
        logic        ePred;
        logic        eLane;
        logic        eMisp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fd_enable;
    logic        fd_flush;
    logic [31:0] f_pc_top;
    logic [31:0] f_pc_bot;
    logic [31:0] f_insn_top;
    logic [31:0] f_insn_bot;
    logic        branchPredictedTaken;
    logic        d_pred_lane;
    logic        x_valid;
    logic [31:0] x_pc;
    logic        x_taken;
    logic        x_predicted;
    logic        mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int nAssert = 0;
    int nFail   = 0;
    vec_t vecs[$];
    vec_t s;

    always #5 clock = ~clock;

    branch_predictor_dual #(.INDEX_BITS(6)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .fd_enable           (fd_enable),
        .fd_flush            (fd_flush),
        .f_pc_top            (f_pc_top),
        .f_pc_bot            (f_pc_bot),
        .f_insn_top          (f_insn_top),
        .f_insn_bot          (f_insn_bot),
        .branchPredictedTaken(branchPredictedTaken),
        .d_pred_lane         (d_pred_lane),
        .x_valid             (x_valid),
        .x_pc                (x_pc),
        .x_taken             (x_taken),
        .x_predicted         (x_predicted),
        .mispredict          (mispredict),
        .stat_branches       (stat_branches),
        .stat_mispredicts    (stat_mispredicts)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [31:0] pcT, input logic [31:0] inT,
        input logic [31:0] pcB, input logic [31:0] inB,
        input logic xv, input logic [31:0] xpc,
        input logic xt, input logic xp,
        input logic ep, input logic el, input logic em
    );
        vec_t v;
        v.en = 1'b1;  v.fl = 1'b0;
        v.pcT = pcT;  v.inT = inT;
        v.pcB = pcB;  v.inB = inB;
        v.xv = xv;    v.xpc = xpc;
        v.xt = xt;    v.xp = xp;
        v.ePred = ep; v.eLane = el; v.eMisp = em;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        fd_enable   = v.en;
        fd_flush    = v.fl;
        f_pc_top    = v.pcT;
        f_insn_top  = v.inT;
        f_pc_bot    = v.pcB;
        f_insn_bot  = v.inB;
        x_valid     = v.xv;
        x_pc        = v.xpc;
        x_taken     = v.xt;
        x_predicted = v.xp;
    endtask

    // Drive one cycle, check the combinational flag, then the F/D outputs.
    task automatic applyVec(input vec_t v, input string name);
        drive(v);
        #1;
        check($sformatf("%s misp", name), mispredict, v.eMisp);
        @(posedge clock);
        #1;
        check($sformatf("%s pred", name), branchPredictedTaken, v.ePred);
        check($sformatf("%s lane", name), d_pred_lane, v.eLane);
    endtask

    initial begin
        // pcT inT pcB inB | xv xpc xt xp | pred lane misp
        vecs.push_back(mk(5, BNE, 6, ADD,    0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, ADD, 1, ADD,    1, 5, 1, 0,  0, 0, 1));
        vecs.push_back(mk(0, ADD, 1, ADD,    1, 5, 1, 1,  0, 0, 0));
        vecs.push_back(mk(5, BNE, 6, ADD,    0, 0, 0, 0,  1, 0, 0));
        vecs.push_back(mk(0, ADD, 1, ADD,    1, 5, 1, 1,  0, 0, 0));
        vecs.push_back(mk(0, ADD, 1, ADD,    1, 5, 1, 1,  0, 0, 0));
        vecs.push_back(mk(0, ADD, 1, ADD,    1, 5, 1, 1,  0, 0, 0));
        vecs.push_back(mk(0, ADD, 1, ADD,    1, 5, 0, 0,  0, 0, 0));
        vecs.push_back(mk(5, BNE, 6, ADD,    0, 0, 0, 0,  1, 0, 0));
        vecs.push_back(mk(5, BNE, 6, ADD,    1, 5, 0, 0,  0, 0, 0));
        vecs.push_back(mk(5, BNE, 6, ADD,    1, 5, 1, 1,  1, 0, 0));
        vecs.push_back(mk(69, BNE, 70, ADD,  0, 0, 0, 0,  1, 0, 0));
        vecs.push_back(mk(0, ADD, 1, ADD,    1, 12, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, ADD, 1, ADD,    1, 12, 1, 1, 0, 0, 0));
        vecs.push_back(mk(11, ADD, 12, BLT,  0, 0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(0, ADD, 1, ADD,    1, 21, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, ADD, 1, ADD,    1, 21, 1, 1, 0, 0, 0));
        vecs.push_back(mk(20, BEX, 21, BNE,  0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(12, NEAR, 13, ADD, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, ADD, 21, BNE,   0, 0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(11, ADD, 12, BEX,  0, 0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(12, BLT, 13, ADD,  0, 0, 0, 0,  1, 0, 0));
        vecs.push_back(mk(127, BNE, 0, ADD,  1, 63, 1, 1, 1, 0, 0));
        vecs.push_back(mk(64, BNE, 65, ADD,  0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, ADD, 1, ADD,    0, 5, 1, 0,  0, 0, 0));

        reset_n = 1'b0;
        drive(mk(5, BNE, 6, ADD, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clock);
        #1;
        check("reset pred", branchPredictedTaken, 0);
        check("reset lane", d_pred_lane, 0);
        check("reset branches", stat_branches, 0);
        check("reset mispredicts", stat_mispredicts, 0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            applyVec(vecs[i], $sformatf("vec%0d", i));
        end
        check("table branches", stat_branches, 13);
        check("table mispredicts", stat_mispredicts, 1);

        // Stall holds the output while training continues underneath.
        applyVec(mk(0, ADD, 21, BNE, 0, 0, 0, 0, 1, 1, 0), "stall load");
        s = mk(0, BNE, 1, ADD, 1, 0, 1, 1, 1, 1, 0);
        s.en = 1'b0;
        applyVec(s, "stall1");
        s = mk(64, BLT, 1, ADD, 0, 0, 0, 0, 1, 1, 0);
        s.en = 1'b0;
        applyVec(s, "stall2");
        s = mk(5, BEX, 6, BNE, 0, 0, 0, 0, 1, 1, 0);
        s.en = 1'b0;
        applyVec(s, "stall3");
        s = mk(0, BNE, 1, ADD, 0, 0, 0, 0, 0, 0, 0);
        s.en = 1'b0;
        s.fl = 1'b1;
        applyVec(s, "flush stalled");
        applyVec(mk(21, ADD, 21, BNE, 0, 0, 0, 0, 1, 1, 0), "reload");
        s = mk(0, BNE, 1, ADD, 0, 0, 0, 0, 0, 0, 0);
        s.fl = 1'b1;
        applyVec(s, "flush enabled");
        applyVec(mk(0, BNE, 1, ADD, 0, 0, 0, 0, 1, 0, 0), "trained in stall");

        // Train entry 7 to strong-taken, then lose it to a reset pulse.
        applyVec(mk(0, ADD, 1, ADD, 1, 7, 1, 1, 0, 0, 0), "train7 a");
        applyVec(mk(0, ADD, 1, ADD, 1, 7, 1, 1, 0, 0, 0), "train7 b");
        applyVec(mk(7, BNE, 8, ADD, 0, 0, 0, 0, 1, 0, 0), "pc7 trained");
        reset_n = 1'b0;
        #1;
        check("async pred", branchPredictedTaken, 0);
        check("async lane", d_pred_lane, 0);
        check("async branches", stat_branches, 0);
        check("async mispredicts", stat_mispredicts, 0);
        #3;
        reset_n = 1'b1;
        applyVec(mk(7, BNE, 8, ADD, 0, 0, 0, 0, 0, 0, 0), "pc7 post reset");
        applyVec(mk(0, BNE, 1, ADD, 0, 0, 0, 0, 0, 0, 0), "pc0 post reset");

        // Mispredict pattern 1,0,1,1.
        applyVec(mk(0, ADD, 1, ADD, 1, 30, 1, 0, 0, 0, 1), "res1");
        applyVec(mk(0, ADD, 1, ADD, 1, 30, 0, 0, 0, 0, 0), "res2");
        applyVec(mk(0, ADD, 1, ADD, 1, 30, 0, 1, 0, 0, 1), "res3");
        applyVec(mk(0, ADD, 1, ADD, 1, 30, 1, 0, 0, 0, 1), "res4");
        check("stat branches", stat_branches, 4);
        check("stat mispredicts", stat_mispredicts, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAssert, nFail);
        $finish;
    end

endmodule
